// File: rtl/writeback_if.sv
// writeback_if - bundle of the writeback stage's execute, decode, host and
// status signals.
//   slave  : seen by the writeback stage (results/reads/host in, status out)
//   master : seen by whoever drives the stage (execute/decode/host/bench)
// Signals:
//   v_i/stall_o/wb_i/rd_num_i/rd_data_i : result handshake from execute
//   ra_i/rb_i -> ra_data_o/rb_data_o    : decode read ports (combinational)
//   host_we_i/host_addr_i/host_data_i   : host/debug register write
//   empty_o, retired_o                  : queue status and commit counter
interface writeback_if #(
  parameter int WORD = 32,
  parameter int W_RD = 5
);
  logic            v_i;
  logic            stall_o;
  logic            wb_i;
  logic [W_RD-1:0] rd_num_i;
  logic [WORD-1:0] rd_data_i;
  logic [W_RD-1:0] ra_i;
  logic [W_RD-1:0] rb_i;
  logic [WORD-1:0] ra_data_o;
  logic [WORD-1:0] rb_data_o;
  logic            host_we_i;
  logic [W_RD-1:0] host_addr_i;
  logic [WORD-1:0] host_data_i;
  logic            empty_o;
  logic [31:0]     retired_o;

  modport slave (
    input  v_i, wb_i, rd_num_i, rd_data_i, ra_i, rb_i,
           host_we_i, host_addr_i, host_data_i,
    output stall_o, ra_data_o, rb_data_o, empty_o, retired_o
  );

  modport master (
    output v_i, wb_i, rd_num_i, rd_data_i, ra_i, rb_i,
           host_we_i, host_addr_i, host_data_i,
    input  stall_o, ra_data_o, rb_data_o, empty_o, retired_o
  );
endinterface

// File: rtl/writeback.sv
// writeback - final pipeline stage.
// Buffers execute results in a 2-entry in-order queue, drains one entry per
// cycle into the register file, forwards pending entries to two read ports,
// and lets a host write port pre-empt the drain for a cycle.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : writeback_if.slave (handshake, read ports, host port, status)
// Build option:
//   VENUS_R0_ZERO_EN - r0 hardwired to zero (writes dropped, reads return 0,
//                      queued r0 entries still pop and still count as retired)
module writeback #(
  parameter int WORD = 32,
  parameter int W_RD = 5
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
);
  localparam int N_RF = 1 << W_RD;

  // Queue storage: slot 0 is always the head, slot 1 the tail when count==2.
  logic [W_RD-1:0] num_r  [2];
  logic [WORD-1:0] data_r [2];
  logic [1:0]      count_r;
  logic            stall_r;
  logic            empty_r;
  logic [31:0]     retired_r;
  logic [WORD-1:0] rf_r [N_RF];

  logic            pop_s;
  logic            push_s;
  logic [1:0]      count_nxt_s;
  logic            wr_en_s;
  logic            rf_we_s;
  logic [W_RD-1:0] rf_addr_s;
  logic [WORD-1:0] rf_wdata_s;

  // Read mux: tail beats head beats register file.
  function automatic logic [WORD-1:0] read_sel(
    input logic [W_RD-1:0] a,
    input logic [1:0]      cnt,
    input logic [W_RD-1:0] n0,
    input logic [WORD-1:0] d0,
    input logic [W_RD-1:0] n1,
    input logic [WORD-1:0] d1,
    input logic [WORD-1:0] rfv
  );
    logic [WORD-1:0] r;
`ifdef VENUS_R0_ZERO_EN
    if (a == {W_RD{1'b0}}) begin
      r = {WORD{1'b0}};
    end else
`endif
    if ((cnt == 2'd2) && (n1 == a)) begin
      r = d1;
    end else if ((cnt != 2'd0) && (n0 == a)) begin
      r = d0;
    end else begin
      r = rfv;
    end
    return r;
  endfunction

  // Handshake decode and next occupancy; push is only possible below full.
  always_comb begin
    pop_s  = (count_r != 2'd0) && !bus.host_we_i;
    push_s = bus.v_i && bus.wb_i && !stall_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Shared register-file write port: host first, otherwise the queue head.
  always_comb begin
    if (bus.host_we_i) begin
      wr_en_s    = 1'b1;
      rf_addr_s  = bus.host_addr_i;
      rf_wdata_s = bus.host_data_i;
    end else if (pop_s) begin
      wr_en_s    = 1'b1;
      rf_addr_s  = num_r[0];
      rf_wdata_s = data_r[0];
    end else begin
      wr_en_s    = 1'b0;
      rf_addr_s  = {W_RD{1'b0}};
      rf_wdata_s = {WORD{1'b0}};
    end
  end

`ifdef VENUS_R0_ZERO_EN
  assign rf_we_s = wr_en_s && (rf_addr_s != {W_RD{1'b0}});
`else
  assign rf_we_s = wr_en_s;
`endif

  // Queue shift/insert plus registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        num_r[i]  <= {W_RD{1'b0}};
        data_r[i] <= {WORD{1'b0}};
      end
      count_r   <= 2'd0;
      stall_r   <= 1'b0;
      empty_r   <= 1'b1;
      retired_r <= 32'd0;
    end else begin
      if (pop_s) begin
        num_r[0]  <= num_r[1];
        data_r[0] <= data_r[1];
      end
      // With a pop in flight the only legal occupancy is 1, so the new entry
      // lands in the slot the head just vacated (overriding the shift).
      if (push_s) begin
        if (pop_s || (count_r == 2'd0)) begin
          num_r[0]  <= bus.rd_num_i;
          data_r[0] <= bus.rd_data_i;
        end else begin
          num_r[1]  <= bus.rd_num_i;
          data_r[1] <= bus.rd_data_i;
        end
      end
      count_r <= count_nxt_s;
      stall_r <= (count_nxt_s == 2'd2);
      empty_r <= (count_nxt_s == 2'd0);
      if (pop_s) begin
        retired_r <= retired_r + 32'd1;
      end
    end
  end

  // Architectural register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_RF; i++) begin
        rf_r[i] <= {WORD{1'b0}};
      end
    end else if (rf_we_s) begin
      rf_r[rf_addr_s] <= rf_wdata_s;
    end
  end

  // Decode read ports with forwarding from pending entries.
  always_comb begin
    bus.ra_data_o = read_sel(bus.ra_i, count_r, num_r[0], data_r[0],
                             num_r[1], data_r[1], rf_r[bus.ra_i]);
    bus.rb_data_o = read_sel(bus.rb_i, count_r, num_r[0], data_r[0],
                             num_r[1], data_r[1], rf_r[bus.rb_i]);
  end

  assign bus.stall_o   = stall_r;
  assign bus.empty_o   = empty_r;
  assign bus.retired_o = retired_r;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback - scoreboard bench for writeback. Stimulus queues expected
// values tagged with the cycle they apply to; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_writeback;
  localparam int WORD = 32;
  localparam int W_RD = 5;

  localparam int K_RA = 0;
  localparam int K_RB = 1;
  localparam int K_STALL = 2;
  localparam int K_EMPTY = 3;
  localparam int K_RET = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int          stamp;
    int          kind;
    string       nm;
    logic [31:0] exp;
  } chk_t;
  chk_t sb[$];

  writeback_if #(.WORD(WORD), .W_RD(W_RD)) bus ();
  writeback #(.WORD(WORD), .W_RD(W_RD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_chk(input int kind, input string nm, input logic [31:0] v);
    chk_t c;
    c.stamp = cyc;
    c.kind  = kind;
    c.nm    = nm;
    c.exp   = v;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic [4:0] rd,
                       input logic [31:0] d);
    bus.v_i = v; bus.wb_i = wb; bus.rd_num_i = rd; bus.rd_data_i = d;
  endtask

  task automatic host(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.host_we_i = we; bus.host_addr_i = a; bus.host_data_i = d;
  endtask

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RA:    return bus.ra_data_o;
      K_RB:    return bus.rb_data_o;
      K_STALL: return {31'd0, bus.stall_o};
      K_EMPTY: return {31'd0, bus.empty_o};
      K_RET:   return bus.retired_o;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every expectation stamped for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
        chk_t c;
        logic [31:0] a;
        c = sb.pop_front();
        a = actual(c.kind);
        n_cmp++;
        if (c.stamp != cyc || a !== c.exp) begin
          n_bad++;
          $display("FAIL %s @cyc%0d: got 0x%08h want 0x%08h", c.nm, cyc, a, c.exp);
        end
      end
    end
  end

  logic [31:0] r0_exp;

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    host(1'b0, 5'd0, 32'd0);
    bus.ra_i = 5'd0;
    bus.rb_i = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state: every register reads 0 on both ports.
    exp_chk(K_STALL, "rst_stall", 32'd0);
    exp_chk(K_EMPTY, "rst_empty", 32'd1);
    exp_chk(K_RET,   "rst_retired", 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.ra_i = 5'(i);
      bus.rb_i = 5'(31 - i);
      exp_chk(K_RA, "rst_ra", 32'd0);
      exp_chk(K_RB, "rst_rb", 32'd0);
      tick();
    end

    // Accept r3, forwarded next cycle, from RF the cycle after.
    drive(1'b1, 1'b1, 5'd3, 32'h1234_5678);
    bus.ra_i = 5'd3;
    exp_chk(K_RA, "no_fwd_incoming", 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    exp_chk(K_RA, "fwd_r3", 32'h1234_5678);
    exp_chk(K_EMPTY, "r3_pending", 32'd0);
    exp_chk(K_RET, "r3_ret0", 32'd0);
    tick();
    exp_chk(K_RA, "rf_r3", 32'h1234_5678);
    exp_chk(K_RET, "r3_ret1", 32'd1);
    exp_chk(K_EMPTY, "r3_empty", 32'd1);
    tick();

    // Back-pressure: two host cycles while r1, r2, r3 arrive back-to-back.
    drive(1'b1, 1'b1, 5'd1, 32'd1);
    host(1'b1, 5'd10, 32'hA0);
    exp_chk(K_STALL, "bp_a_stall", 32'd0);
    tick();
    drive(1'b1, 1'b1, 5'd2, 32'd2);
    host(1'b1, 5'd11, 32'hB0);
    exp_chk(K_STALL, "bp_b_stall", 32'd0);
    tick();
    drive(1'b1, 1'b1, 5'd3, 32'd3);
    host(1'b0, 5'd0, 32'd0);
    bus.ra_i = 5'd2;
    bus.rb_i = 5'd1;
    exp_chk(K_STALL, "bp_c_stall", 32'd1);
    exp_chk(K_RA, "bp_tail_fwd", 32'd2);
    exp_chk(K_RB, "bp_head_fwd", 32'd1);
    tick();
    exp_chk(K_STALL, "bp_d_stall", 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    exp_chk(K_RET, "bp_e_ret", 32'd3);
    exp_chk(K_EMPTY, "bp_e_empty", 32'd0);
    tick();
    bus.ra_i = 5'd1;
    bus.rb_i = 5'd2;
    exp_chk(K_RET, "bp_f_ret", 32'd4);
    exp_chk(K_EMPTY, "bp_f_empty", 32'd1);
    exp_chk(K_RA, "bp_r1", 32'd1);
    exp_chk(K_RB, "bp_r2", 32'd2);
    tick();
    bus.ra_i = 5'd3;
    bus.rb_i = 5'd10;
    exp_chk(K_RA, "bp_r3", 32'd3);
    exp_chk(K_RB, "bp_r10", 32'hA0);
    exp_chk(K_RET, "bp_once", 32'd4);
    tick();
    bus.rb_i = 5'd11;
    exp_chk(K_RB, "bp_r11", 32'hB0);
    tick();

    // Host write to r5 while a queued r5 is blocked: queued value wins.
    drive(1'b1, 1'b1, 5'd5, 32'hBB);
    bus.ra_i = 5'd5;
    exp_chk(K_RA, "r5_before", 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    host(1'b1, 5'd5, 32'hAA);
    exp_chk(K_RA, "r5_q", 32'hBB);
    exp_chk(K_EMPTY, "r5_pending", 32'd0);
    tick();
    host(1'b0, 5'd0, 32'd0);
    exp_chk(K_RA, "r5_blocked", 32'hBB);
    exp_chk(K_RET, "r5_ret_hold", 32'd4);
    tick();
    exp_chk(K_RA, "r5_final", 32'hBB);
    exp_chk(K_RET, "r5_ret", 32'd5);
    exp_chk(K_EMPTY, "r5_empty", 32'd1);
    tick();

    // v_i with wb_i=0 is consumed without queuing.
    drive(1'b1, 1'b0, 5'd7, 32'h77);
    bus.ra_i = 5'd7;
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    exp_chk(K_EMPTY, "nowb_empty", 32'd1);
    exp_chk(K_RET, "nowb_ret", 32'd5);
    exp_chk(K_RA, "nowb_r7", 32'd0);
    tick();
    exp_chk(K_RET, "nowb_ret2", 32'd5);
    tick();

    // r0 handling (hardwired zero only when the option is built in).
`ifdef VENUS_R0_ZERO_EN
    r0_exp = 32'd0;
`else
    r0_exp = 32'hFFFF;
`endif
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF);
    bus.ra_i = 5'd0;
    exp_chk(K_RA, "r0_incoming", 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    exp_chk(K_RA, "r0_pending", r0_exp);
    tick();
    host(1'b1, 5'd0, 32'h55);
    exp_chk(K_RA, "r0_drained", r0_exp);
    exp_chk(K_RET, "r0_ret", 32'd6);
    tick();
    host(1'b0, 5'd0, 32'd0);
`ifdef VENUS_R0_ZERO_EN
    exp_chk(K_RA, "r0_host", 32'd0);
`else
    exp_chk(K_RA, "r0_host", 32'h55);
`endif
    tick();

    // Two entries for the same register: tail outranks head.
    drive(1'b1, 1'b1, 5'd9, 32'h91);
    host(1'b1, 5'd20, 32'd0);
    bus.ra_i = 5'd9;
    tick();
    drive(1'b1, 1'b1, 5'd9, 32'h92);
    host(1'b1, 5'd21, 32'd0);
    exp_chk(K_RA, "r9_head", 32'h91);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    host(1'b0, 5'd0, 32'd0);
    exp_chk(K_RA, "r9_tail_prio", 32'h92);
    exp_chk(K_STALL, "r9_full", 32'd1);
    tick();
    exp_chk(K_RA, "r9_head2", 32'h92);
    tick();
    exp_chk(K_RA, "r9_rf", 32'h92);
    exp_chk(K_EMPTY, "r9_empty", 32'd1);
    exp_chk(K_RET, "r9_ret", 32'd8);
    tick();
    tick();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
